// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, forwarding selects
// and the memory/write-back control bundle carried down the pipe.
package id_ex_stage_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SA_W     = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd12;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic reg_we;
        logic mem_rd;
        logic mem_wr;
    } ex_ctl_t;

    localparam ex_ctl_t EX_CTL_NONE = '{reg_we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0};

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass for one EX source register: EX/MEM beats MEM/WB beats the
// registered read data; register 0 is hard-wired and never takes a bypass.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              exm_reg_we_i,
    input  logic [REG_AW-1:0] exm_dst_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              wb_reg_we_i,
    input  logic [REG_AW-1:0] wb_dst_i,
    input  logic [DATA_W-1:0] wb_result_i,
    output logic [DATA_W-1:0] data_o
);

    fwd_sel_e sel;
    logic     src_nz;
    logic     exm_hit;
    logic     wb_hit;

    assign src_nz  = (src_i != '0);
    assign exm_hit = src_nz && exm_reg_we_i && (exm_dst_i == src_i);
    assign wb_hit  = src_nz && wb_reg_we_i  && (wb_dst_i  == src_i);

    // Youngest producer wins.
    always_comb begin
        sel = FWD_RF;
        if (exm_hit) begin
            sel = FWD_EXM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_EXM: data_o = exm_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion,
// flush/hold handling and combinational operand bypass into the ALU inputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [SA_W-1:0]   id_sa,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_uses_rt,
    input  logic [CTL_W-1:0]  id_alu_ctl,
    input  logic              id_src_imm,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              flush,
    input  logic              hold,
    input  logic              exm_reg_we,
    input  logic [REG_AW-1:0] exm_dst,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_we,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_result,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [CTL_W-1:0]  ex_alu_ctl,
    output logic [DATA_W-1:0] ex_alu_a,
    output logic [DATA_W-1:0] ex_alu_b,
    output logic [SA_W-1:0]   ex_sa,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr
);

    logic              valid_q,   valid_d;
    ex_ctl_t           ctl_q,     ctl_d;
    logic [CTL_W-1:0]  alu_ctl_q, alu_ctl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [SA_W-1:0]   sa_q,      sa_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dst_q,     dst_d;
    logic              src_imm_q, src_imm_d;

    logic              load_use;
    logic              rs_dep;
    logic              rt_dep;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // A load in EX cannot bypass its data to the instruction right behind it.
    assign rs_dep   = (dst_q == id_rs);
    assign rt_dep   = id_uses_rt && (dst_q == id_rt);
    assign load_use = valid_q && ctl_q.mem_rd && (dst_q != '0) && id_valid && (rs_dep || rt_dep);
    assign id_stall = load_use && !flush;

    // Priority: hold freezes everything, then flush/stall/empty ID make a bubble.
    always_comb begin
        valid_d   = valid_q;
        ctl_d     = ctl_q;
        alu_ctl_d = alu_ctl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        sa_d      = sa_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dst_d     = dst_q;
        src_imm_d = src_imm_q;
        if (!hold) begin
            if (flush || load_use || !id_valid) begin
                valid_d   = 1'b0;
                ctl_d     = EX_CTL_NONE;
                alu_ctl_d = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                sa_d      = '0;
                rs_d      = '0;
                rt_d      = '0;
                dst_d     = '0;
                src_imm_d = 1'b0;
            end else begin
                valid_d   = 1'b1;
                ctl_d     = '{reg_we: id_reg_we, mem_rd: id_mem_rd, mem_wr: id_mem_wr};
                alu_ctl_d = id_alu_ctl;
                rs_data_d = id_rs_data;
                rt_data_d = id_rt_data;
                imm_d     = id_imm;
                sa_d      = id_sa;
                rs_d      = id_rs;
                rt_d      = id_rt;
                dst_d     = id_dst;
                src_imm_d = id_src_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctl_q     <= EX_CTL_NONE;
            alu_ctl_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            sa_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            src_imm_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctl_q     <= ctl_d;
            alu_ctl_q <= alu_ctl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            sa_q      <= sa_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            src_imm_q <= src_imm_d;
        end
    end

    id_ex_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .src_i        (rs_q),
        .rf_data_i    (rs_data_q),
        .exm_reg_we_i (exm_reg_we),
        .exm_dst_i    (exm_dst),
        .exm_result_i (exm_result),
        .wb_reg_we_i  (wb_reg_we),
        .wb_dst_i     (wb_dst),
        .wb_result_i  (wb_result),
        .data_o       (fwd_rs)
    );

    id_ex_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .src_i        (rt_q),
        .rf_data_i    (rt_data_q),
        .exm_reg_we_i (exm_reg_we),
        .exm_dst_i    (exm_dst),
        .exm_result_i (exm_result),
        .wb_reg_we_i  (wb_reg_we),
        .wb_dst_i     (wb_dst),
        .wb_result_i  (wb_result),
        .data_o       (fwd_rt)
    );

    assign ex_valid      = valid_q;
    assign ex_alu_ctl    = alu_ctl_q;
    assign ex_alu_a      = fwd_rs;
    assign ex_alu_b      = src_imm_q ? imm_q : fwd_rt;
    assign ex_sa         = sa_q;
    assign ex_store_data = fwd_rt;
    assign ex_dst        = dst_q;
    assign ex_reg_we     = valid_q && ctl_q.reg_we;
    assign ex_mem_rd     = valid_q && ctl_q.mem_rd;
    assign ex_mem_wr     = valid_q && ctl_q.mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against
// an instruction-level model of what EX should present to the ALU.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_sa;
    logic [AW-1:0] id_rs, id_rt, id_dst;
    logic          id_uses_rt;
    logic [CW-1:0] id_alu_ctl;
    logic          id_src_imm, id_reg_we, id_mem_rd, id_mem_wr;
    logic          flush, hold;
    logic          exm_reg_we;
    logic [AW-1:0] exm_dst;
    logic [DW-1:0] exm_result;
    logic          wb_reg_we;
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] wb_result;
    logic          id_stall, ex_valid;
    logic [CW-1:0] ex_alu_ctl;
    logic [DW-1:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]    ex_sa;
    logic [AW-1:0] ex_dst;
    logic          ex_reg_we, ex_mem_rd, ex_mem_wr;

    int n_vec = 0;
    int n_err = 0;

    // Instruction currently sitting in EX, as the model sees it.
    logic          m_valid;
    logic [DW-1:0] m_rs_data, m_rt_data, m_imm;
    logic [4:0]    m_sa;
    logic [AW-1:0] m_rs, m_rt, m_dst;
    logic [CW-1:0] m_ctl;
    logic          m_src_imm, m_we, m_rd, m_wr;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CTL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_sa(id_sa),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .id_uses_rt(id_uses_rt),
        .id_alu_ctl(id_alu_ctl), .id_src_imm(id_src_imm), .id_reg_we(id_reg_we),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .flush(flush), .hold(hold),
        .exm_reg_we(exm_reg_we), .exm_dst(exm_dst), .exm_result(exm_result),
        .wb_reg_we(wb_reg_we), .wb_dst(wb_dst), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_sa(ex_sa),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_reg_we(ex_reg_we),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
    );

    function automatic logic model_stall();
        if (flush || !m_valid || !m_rd || m_dst == 0 || !id_valid) return 1'b0;
        return (m_dst == id_rs) || (id_uses_rt && m_dst == id_rt);
    endfunction

    function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] src, input logic [DW-1:0] rf);
        if (src == 0) return rf;
        if (exm_reg_we && exm_dst == src) return exm_result;
        if (wb_reg_we && wb_dst == src) return wb_result;
        return rf;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_sa = 0;
        m_rs = 0; m_rt = 0; m_dst = 0; m_ctl = 0; m_src_imm = 0;
        m_we = 0; m_rd = 0; m_wr = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        logic st;
        st = model_stall();
        if (!rst_n) model_clear();
        else if (hold) begin end
        else if (flush || st || !id_valid) model_clear();
        else begin
            m_valid = 1; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
            m_sa = id_sa; m_rs = id_rs; m_rt = id_rt; m_dst = id_dst; m_ctl = id_alu_ctl;
            m_src_imm = id_src_imm; m_we = id_reg_we; m_rd = id_mem_rd; m_wr = id_mem_wr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_sa = 0;
        id_rs = 0; id_rt = 0; id_dst = 0; id_uses_rt = 0; id_alu_ctl = 0;
        id_src_imm = 0; id_reg_we = 0; id_mem_rd = 0; id_mem_wr = 0;
        flush = 0; hold = 0;
        exm_reg_we = 0; exm_dst = 0; exm_result = 0;
        wb_reg_we = 0; wb_dst = 0; wb_result = 0;
    endtask

    task automatic drive_fwd_random();
        exm_reg_we = 1'($urandom_range(0, 1)); exm_dst = AW'($urandom_range(0, 7)); exm_result = $urandom;
        wb_reg_we  = 1'($urandom_range(0, 1)); wb_dst  = AW'($urandom_range(0, 7)); wb_result  = $urandom;
    endtask

    task automatic drive_random();
        id_valid   = ($urandom_range(0, 7) != 0);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_sa      = 5'($urandom);
        id_rs      = AW'($urandom_range(0, 7));
        id_rt      = AW'($urandom_range(0, 7));
        id_dst     = AW'($urandom_range(0, 7));
        id_uses_rt = 1'($urandom_range(0, 1));
        id_alu_ctl = CW'($urandom);
        id_src_imm = 1'($urandom_range(0, 1));
        id_reg_we  = 1'($urandom_range(0, 1));
        id_mem_rd  = ($urandom_range(0, 2) == 0);
        id_mem_wr  = 1'($urandom_range(0, 1));
        flush      = ($urandom_range(0, 7) == 0);
        hold       = ($urandom_range(0, 7) == 0);
        drive_fwd_random();
    endtask

    task automatic load_r(input logic [AW-1:0] r);
        clear_inputs();
        id_valid = 1; id_mem_rd = 1; id_reg_we = 1; id_dst = r; id_rs = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            drive_random();
            tick();
        end
        n_vec++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        n_vec++; if ({ex_reg_we, ex_mem_rd, ex_mem_wr} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b exp 000", {ex_reg_we, ex_mem_rd, ex_mem_wr}); end
        n_vec++; if ({ex_alu_ctl, ex_alu_a, ex_alu_b, ex_sa, ex_store_data, ex_dst} !== '0) begin
            n_err++; $display("FAIL reset_data a=%h b=%h st=%h ctl=%h sa=%h dst=%h exp 0", ex_alu_a, ex_alu_b, ex_store_data, ex_alu_ctl, ex_sa, ex_dst);
        end
        n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b exp 0", id_stall); end
        rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_capture();
        clear_inputs();
        id_valid = 1; id_rs = 1; id_rt = 2; id_dst = 3; id_rs_data = 5; id_rt_data = 7;
        id_alu_ctl = CW'(ALU_ADD); id_reg_we = 1; id_sa = 13;
        tick();
        clear_inputs();
        n_vec++; if (ex_alu_a !== 32'd5) begin n_err++; $display("FAIL capture_a got %h exp 5", ex_alu_a); end
        n_vec++; if (ex_alu_b !== 32'd7) begin n_err++; $display("FAIL capture_b got %h exp 7", ex_alu_b); end
        n_vec++; if (ex_alu_ctl !== 5'd2) begin n_err++; $display("FAIL capture_ctl got %h exp 2", ex_alu_ctl); end
        n_vec++; if ({ex_valid, ex_reg_we} !== 2'b11) begin n_err++; $display("FAIL capture_valid got %b exp 11", {ex_valid, ex_reg_we}); end
        n_vec++; if ({ex_sa, ex_dst} !== {5'd13, 5'd3}) begin n_err++; $display("FAIL capture_sa_dst got %h/%h exp d/3", ex_sa, ex_dst); end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        id_valid = 1; id_rs = 3; id_rs_data = 32'h11;
        tick();
        exm_reg_we = 1; exm_dst = 3; exm_result = 32'hAA;
        wb_reg_we = 1; wb_dst = 3; wb_result = 32'hBB;
        #1;
        n_vec++; if (ex_alu_a !== 32'hAA) begin n_err++; $display("FAIL fwd_exm got %h exp aa", ex_alu_a); end
        exm_reg_we = 0; #1;
        n_vec++; if (ex_alu_a !== 32'hBB) begin n_err++; $display("FAIL fwd_wb got %h exp bb", ex_alu_a); end
        wb_reg_we = 0; #1;
        n_vec++; if (ex_alu_a !== 32'h11) begin n_err++; $display("FAIL fwd_rf got %h exp 11", ex_alu_a); end
        id_rs = 0; id_rs_data = 32'h22;
        tick();
        exm_reg_we = 1; exm_dst = 0; wb_reg_we = 1; wb_dst = 0; #1;
        n_vec++; if (ex_alu_a !== 32'h22) begin n_err++; $display("FAIL fwd_r0 got %h exp 22", ex_alu_a); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        load_r(4);
        id_valid = 1; id_rs = 5; id_rt = 4; id_uses_rt = 1; id_rt_data = 32'h40;
        id_alu_ctl = CW'(ALU_SUB); id_dst = 6; id_reg_we = 1;
        #1;
        n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0b exp 1", id_stall); end
        tick();
        n_vec++; if ({ex_valid, ex_reg_we, ex_alu_ctl} !== 7'd0) begin n_err++; $display("FAIL lu_bubble got %b exp 0", {ex_valid, ex_reg_we, ex_alu_ctl}); end
        n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_release got %0b exp 0", id_stall); end
        wb_reg_we = 1; wb_dst = 4; wb_result = 32'h44;
        tick();
        n_vec++; if ({ex_valid, ex_alu_ctl} !== {1'b1, CW'(ALU_SUB)}) begin n_err++; $display("FAIL lu_capture got %b exp %b", {ex_valid, ex_alu_ctl}, {1'b1, CW'(ALU_SUB)}); end
        n_vec++; if (ex_alu_b !== 32'h44 || ex_store_data !== 32'h44) begin n_err++; $display("FAIL lu_fwd got b=%h st=%h exp 44", ex_alu_b, ex_store_data); end
        load_r(4);
        id_valid = 1; id_rs = 5; id_rt = 4; id_uses_rt = 0; #1;
        n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_no_rt got %0b exp 0", id_stall); end
        load_r(0);
        id_valid = 1; id_rs = 0; #1;
        n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL lu_r0 got %0b exp 0", id_stall); end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush_hold();
        load_r(4);
        id_valid = 1; id_rs = 4; flush = 1; #1;
        n_vec++; if (id_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got %0b exp 0", id_stall); end
        hold = 1;
        tick();
        n_vec++; if ({ex_valid, ex_mem_rd, ex_dst} !== {2'b11, 5'd4}) begin n_err++; $display("FAIL fl_hold got %b exp 1100100", {ex_valid, ex_mem_rd, ex_dst}); end
        flush = 0; #1;
        n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall got %0b exp 1", id_stall); end
        hold = 0; flush = 1;
        tick();
        n_vec++; if ({ex_valid, ex_mem_rd, ex_dst} !== 7'd0) begin n_err++; $display("FAIL fl_bubble got %b exp 0", {ex_valid, ex_mem_rd, ex_dst}); end
        clear_inputs();
    endtask

    task automatic test_imm();
        clear_inputs();
        id_valid = 1; id_src_imm = 1; id_imm = 32'hFFFF_FFFC; id_rt = 6; id_rt_data = 1;
        id_mem_wr = 1; id_alu_ctl = CW'(ALU_ADD);
        tick();
        clear_inputs();
        exm_reg_we = 1; exm_dst = 6; exm_result = 9; #1;
        n_vec++; if (ex_alu_b !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL imm_b got %h exp fffffffc", ex_alu_b); end
        n_vec++; if (ex_store_data !== 32'd9) begin n_err++; $display("FAIL imm_store got %h exp 9", ex_store_data); end
        n_vec++; if ({ex_mem_wr, ex_reg_we} !== 2'b10) begin n_err++; $display("FAIL imm_ctl got %b exp 10", {ex_mem_wr, ex_reg_we}); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        load_r(4);
        id_valid = 1; id_rs = 4; #1;
        n_vec++; if (id_stall !== 1'b1) begin n_err++; $display("FAIL rms_pre got %0b exp 1", id_stall); end
        rst_n = 0;
        tick();
        n_vec++; if ({ex_valid, id_stall} !== 2'b00) begin n_err++; $display("FAIL rms_post got %b exp 00", {ex_valid, id_stall}); end
        rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_random();
        logic          exp_stall;
        logic [DW-1:0] exp_a, exp_rt, exp_b;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            drive_random();
            #1;
            exp_stall = model_stall();
            n_vec++; if (id_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d] got %0b exp %0b", i, id_stall, exp_stall); end
            tick();
            drive_fwd_random();
            #1;
            exp_a  = model_fwd(m_rs, m_rs_data);
            exp_rt = model_fwd(m_rt, m_rt_data);
            exp_b  = m_src_imm ? m_imm : exp_rt;
            n_vec++; if (ex_valid !== m_valid || ex_alu_ctl !== m_ctl || ex_sa !== m_sa || ex_dst !== m_dst) begin
                n_err++; $display("FAIL rnd_fields[%0d] got v=%0b ctl=%h sa=%h dst=%h exp v=%0b ctl=%h sa=%h dst=%h",
                                  i, ex_valid, ex_alu_ctl, ex_sa, ex_dst, m_valid, m_ctl, m_sa, m_dst);
            end
            n_vec++; if ({ex_reg_we, ex_mem_rd, ex_mem_wr} !== {m_valid & m_we, m_valid & m_rd, m_valid & m_wr}) begin
                n_err++; $display("FAIL rnd_ctl[%0d] got %b exp %b", i, {ex_reg_we, ex_mem_rd, ex_mem_wr}, {m_valid & m_we, m_valid & m_rd, m_valid & m_wr});
            end
            n_vec++; if (ex_alu_a !== exp_a || ex_alu_b !== exp_b || ex_store_data !== exp_rt) begin
                n_err++; $display("FAIL rnd_data[%0d] got a=%h b=%h st=%h exp a=%h b=%h st=%h",
                                  i, ex_alu_a, ex_alu_b, ex_store_data, exp_a, exp_b, exp_rt);
            end
        end
        rst_n = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_clear();
        rst_n = 0;
        test_reset();
        test_capture();
        test_fwd_priority();
        test_load_use();
        test_flush_hold();
        test_imm();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
